// File: rtl/multicycle_sequencer_pkg.sv
// State encodings and PC-source selects shared by the multi-cycle sequencer and its bench.
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_ERR    = 3'd7
  } state_e;

  localparam logic [1:0] PC_SRC_SEQ = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;

endpackage

// File: rtl/multicycle_sequencer_timer.sv
// Memory wait-cycle counter: clears on request, counts unacknowledged cycles, flags the limit.
// hit is combinational from the count so the FSM can weigh it against mem_ack in the same cycle.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(MEM_TIMEOUT);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB over a shared single-port memory.
// Strobes are decoded from state and inputs; a memory timeout parks the FSM in ERR until reset.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_branch,
  input  logic             br_taken,
  input  logic             is_jump,
  input  logic             wb_en,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             alu_out_we,
  output logic             mdr_we,
  output logic             rf_we,
  output logic [2:0]       state,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  logic             waiting;
  logic             to_hit;
  logic             c_load, c_store, c_branch, c_jump;

  // Several class flags at once resolve as load > store > branch > jump.
  assign c_load   = is_load;
  assign c_store  = is_store && !is_load;
  assign c_branch = is_branch && !is_load && !is_store;
  assign c_jump   = is_jump && !is_load && !is_store && !is_branch;

  assign waiting = (state_q == ST_FETCH) || (state_q == ST_MEM);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TO_W       (TO_W)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (!waiting || mem_ack),
    .inc  (waiting && !mem_ack),
    .hit  (to_hit)
  );

  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_SRC_SEQ;
    alu_out_we   = 1'b0;
    mdr_we       = 1'b0;
    rf_we        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (to_hit) begin
          state_d = ST_ERR;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        alu_out_we = 1'b1;
        if (c_branch) begin
          pc_we  = br_taken;
          pc_src = PC_SRC_BR;
        end else if (c_jump) begin
          pc_we  = 1'b1;
          pc_src = PC_SRC_JMP;
        end
        if (c_load || c_store) state_d = ST_MEM;
        else if (wb_en)        state_d = ST_WB;
        else                   retire  = 1'b1;
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = c_store;
        if (mem_ack) begin
          mdr_we = c_load;
          if (c_load) state_d = ST_WB;
          else        retire  = 1'b1;
        end else if (to_hit) begin
          state_d = ST_ERR;
        end
      end
      ST_WB: begin
        rf_we  = wb_en;
        retire = 1'b1;
      end
      ST_ERR: state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
    if (retire) state_d = run ? ST_FETCH : ST_IDLE;
    retired_d = retired_q + CNT_W'(retire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign busy    = (state_q != ST_IDLE) && (state_q != ST_ERR);
  assign err     = (state_q == ST_ERR);
  assign retired = retired_q;

endmodule
